// File: rtl/motion_bus_pkg.sv
// Shared types and constants for the motor register bus arbiter.
// Holds the access-cycle state enum, axis codes and default phase timing.
package motion_bus_pkg;

  localparam int CNT_W = 8;

  localparam int DEF_SETUP_CYCLES  = 1;
  localparam int DEF_STROBE_CYCLES = 4;
  localparam int DEF_HOLD_CYCLES   = 1;

  localparam logic [1:0] AXIS_X = 2'd0;
  localparam logic [1:0] AXIS_Y = 2'd1;
  localparam logic [1:0] AXIS_Z = 2'd2;
  localparam logic [1:0] AXIS_W = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } bus_state_t;

  function automatic logic [3:0] axis_select(input logic [1:0] axis);
    logic [3:0] sel;
    sel = 4'b0000;
    unique case (axis)
      AXIS_X: sel = 4'b0001;
      AXIS_Y: sel = 4'b0010;
      AXIS_Z: sel = 4'b0100;
      AXIS_W: sel = 4'b1000;
      default: sel = 4'b0000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner select; the search starts one past ptr.
// The pointer register itself lives in the parent.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   index
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    winner = '0;
    index  = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found        = 1'b1;
        winner[cand] = 1'b1;
        index        = cand;
      end
    end
  end

endmodule

// File: rtl/motor_bus_arbiter.sv
// Shares the motor register bus between NREQ requesters with round-robin
// arbitration and a fixed setup/strobe/hold access cycle.
module motor_bus_arbiter
  import motion_bus_pkg::*;
#(
  parameter int NREQ          = 3,
  parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [2*NREQ-1:0]    req_axis,
  input  logic [8*NREQ-1:0]    req_addr,
  input  logic [32*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [31:0]          rdata,
  output logic [7:0]           bus_addr,
  output logic [31:0]          bus_wdata,
  input  logic [31:0]          bus_rdata,
  output logic                 bus_rd,
  output logic [3:0]           bus_cs,
  output logic                 bus_oe,
  output logic                 busy
);

  localparam int IW = $clog2(NREQ);

  bus_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    cur_idx;
  logic [1:0]       cur_axis;

  logic [NREQ-1:0]  win_onehot;
  logic [IW-1:0]    win_idx;

  logic [1:0]       axis_arr  [NREQ];
  logic [7:0]       addr_arr  [NREQ];
  logic [31:0]      wdata_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign axis_arr[g]  = req_axis[2*g +: 2];
    assign addr_arr[g]  = req_addr[8*g +: 8];
    assign wdata_arr[g] = req_wdata[32*g +: 32];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req    (req),
    .ptr    (ptr),
    .winner (win_onehot),
    .index  (win_idx)
  );

  // One down-counter times every phase: it is reloaded with (phase length - 1)
  // on entry and the phase ends on the edge where it reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ptr       <= IW'(NREQ - 1);
      cur_idx   <= '0;
      cur_axis  <= '0;
      gnt       <= '0;
      done      <= '0;
      rdata     <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_rd    <= 1'b0;
      bus_cs    <= '0;
      bus_oe    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt       <= win_onehot;
            cur_idx   <= win_idx;
            cur_axis  <= axis_arr[win_idx];
            bus_addr  <= addr_arr[win_idx];
            bus_wdata <= wdata_arr[win_idx];
            bus_rd    <= ~req_wr[win_idx];
            busy      <= 1'b1;
            cnt       <= CNT_W'(SETUP_CYCLES - 1);
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            bus_cs <= axis_select(cur_axis);
            bus_oe <= bus_rd;
            cnt    <= CNT_W'(STROBE_CYCLES - 1);
            state  <= ST_STROBE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_STROBE: begin
          if (cnt == '0) begin
            if (bus_rd) begin
              rdata <= bus_rdata;
            end
            bus_cs <= '0;
            bus_oe <= 1'b0;
            cnt    <= CNT_W'(HOLD_CYCLES - 1);
            state  <= ST_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            done  <= gnt;
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          done  <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
          ptr   <= cur_idx;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
